// File: rtl/sprite_pkg.sv
// sprite_pkg: state encoding, ROM latency limits and width helpers shared by
// the sprite_anim block and its address generator.
package sprite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    AWAIT_POS,
    DRAW,
    NEXT_LINE,
    DONE
  } state_t;

  localparam int unsigned ROM_LAT_MIN = 1;
  localparam int unsigned ROM_LAT_MAX = 3;

  // Bit width needed to index n items, never less than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Keep the ROM read latency inside the supported pipeline depths.
  function automatic int unsigned clamp_lat(input int unsigned lat);
    if (lat < ROM_LAT_MIN) return ROM_LAT_MIN;
    if (lat > ROM_LAT_MAX) return ROM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: converts latched frame plus unscaled sprite coordinates
// into a ROM word address (frame base + row offset + optionally mirrored column).
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned HEIGHT = 16,
  parameter int unsigned FRAMES = 4,
  localparam int unsigned FW  = width_of(FRAMES),
  localparam int unsigned AW  = width_of(WIDTH * HEIGHT * FRAMES),
  localparam int unsigned OXW = width_of(WIDTH),
  localparam int unsigned OYW = width_of(HEIGHT)
) (
  input  logic [FW-1:0]  frame,
  input  logic [OYW-1:0] oy,
  input  logic [OXW-1:0] ox,
  input  logic           flip,
  output logic [AW-1:0]  addr
);

  localparam int unsigned FRAME_SZ = WIDTH * HEIGHT;

  logic [OXW-1:0] col;

  // Mirror the column when requested, then sum frame base, row offset and column.
  always_comb begin
    col  = flip ? (OXW'(WIDTH - 1) - ox) : ox;
    addr = AW'(FRAME_SZ) * AW'(frame) + AW'(WIDTH) * AW'(oy) + AW'(col);
  end

endmodule

// File: rtl/sprite_anim.sv
// sprite_anim: scaled, animated sprite renderer fed from an external ROM.
// Optional feature macro: SPRITE_ANIM_FLIP_EN enables horizontal mirroring;
// when undefined the flip input is ignored.
module sprite_anim
  import sprite_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned HEIGHT    = 16,
  parameter int unsigned FRAMES    = 4,
  parameter int unsigned SCALE_X   = 1,
  parameter int unsigned SCALE_Y   = 1,
  parameter int unsigned COLR_BITS = 12,
  parameter int unsigned CORDW     = 16,
  parameter logic [COLR_BITS-1:0] TRANSP = '0,
  parameter int unsigned ROM_LAT   = 1,
  localparam int unsigned FW = width_of(FRAMES),
  localparam int unsigned AW = width_of(WIDTH * HEIGHT * FRAMES)
) (
  input  logic                    clk_pix,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    line,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic signed [CORDW-1:0] sprx,
  input  logic signed [CORDW-1:0] spry,
  input  logic [FW-1:0]           frame,
  input  logic                    flip,
  output logic [AW-1:0]           rom_addr,
  input  logic [COLR_BITS-1:0]    rom_data,
  output logic [COLR_BITS-1:0]    pix,
  output logic                    drawing,
  output logic                    done
);

  localparam int unsigned OXW = width_of(WIDTH);
  localparam int unsigned OYW = width_of(HEIGHT);
  localparam int unsigned SXW = width_of(SCALE_X);
  localparam int unsigned SYW = width_of(SCALE_Y);
  localparam int unsigned LAT = clamp_lat(ROM_LAT);
  // Address is presented LAT cycles ahead of the pixel, and DRAW is entered
  // one cycle after the trigger, so the trigger sits LAT+1 columns early.
  localparam logic signed [CORDW-1:0] LEAD = CORDW'(LAT + 1);

  state_t state, state_next;
  logic   armed, armed_next;

  logic [OXW-1:0] ox;
  logic [OYW-1:0] oy;
  logic [SXW-1:0] sxc;
  logic [SYW-1:0] syc;
  logic [FW-1:0]  frame_q;
  logic [FW-1:0]  frame_sel;
  logic           flip_eff;
  logic [LAT-1:0] vld_q;
  logic           done_q;

  logic                    col_last;
  logic                    row_last;
  logic signed [CORDW-1:0] trig;

  assign frame_sel = (32'(frame) >= FRAMES) ? FW'(FRAMES - 1) : frame;
  assign col_last  = (sxc == SXW'(SCALE_X - 1)) && (ox == OXW'(WIDTH - 1));
  assign row_last  = (syc == SYW'(SCALE_Y - 1)) && (oy == OYW'(HEIGHT - 1));
  assign trig      = sprx - LEAD;

`ifdef SPRITE_ANIM_FLIP_EN
  logic flip_q;

  // Mirror request is captured once per sprite.
  always_ff @(posedge clk_pix) begin
    if (rst)                flip_q <= 1'b0;
    else if (state == START) flip_q <= flip;
  end

  assign flip_eff = flip_q;
`else
  logic unused_flip;
  assign unused_flip = flip;
  assign flip_eff    = 1'b0;
`endif

  // State and line-arming register.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= armed_next;
    end
  end

  // armed marks that the current screen line still owes the pending row; a
  // line strobe while armed means that row was missed and is counted anyway.
  // A missed final row goes straight to DONE so clipped sprites terminate.
  always_comb begin
    state_next = state;
    armed_next = armed;
    case (state)
      IDLE: begin
        if (line && (sy == spry)) state_next = START;
      end
      START: begin
        state_next = AWAIT_POS;
        armed_next = 1'b1;
      end
      AWAIT_POS: begin
        if (line) begin
          if (armed) state_next = row_last ? DONE : NEXT_LINE;
          else       armed_next = 1'b1;
        end else if (armed && (sx == trig)) begin
          state_next = DRAW;
        end
      end
      DRAW: begin
        if (line) begin
          state_next = row_last ? DONE : NEXT_LINE;
          armed_next = 1'b1;
        end else if (col_last) begin
          state_next = row_last ? DONE : NEXT_LINE;
          armed_next = 1'b0;
        end
      end
      NEXT_LINE: state_next = AWAIT_POS;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Sprite coordinate and scale counters plus the latched frame.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      ox      <= '0;
      oy      <= '0;
      sxc     <= '0;
      syc     <= '0;
      frame_q <= '0;
    end else begin
      case (state)
        START: begin
          frame_q <= frame_sel;
          ox      <= '0;
          oy      <= '0;
          sxc     <= '0;
          syc     <= '0;
        end
        DRAW: begin
          if (line || col_last) begin
            ox  <= '0;
            sxc <= '0;
          end else if (sxc == SXW'(SCALE_X - 1)) begin
            sxc <= '0;
            ox  <= ox + OXW'(1);
          end else begin
            sxc <= sxc + SXW'(1);
          end
        end
        NEXT_LINE: begin
          if (syc == SYW'(SCALE_Y - 1)) begin
            syc <= '0;
            oy  <= oy + OYW'(1);
          end else begin
            syc <= syc + SYW'(1);
          end
        end
        DONE: begin
          oy  <= '0;
          syc <= '0;
        end
        default: ;
      endcase
    end
  end

  // Track which presented addresses will return aligned pixels; a new line
  // discards anything still in flight from an aborted row.
  always_ff @(posedge clk_pix) begin
    if (rst || line) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= (state == DRAW);
      for (int unsigned i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Completion pulse one cycle after DONE is entered.
  always_ff @(posedge clk_pix) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= (state == DONE);
  end

  sprite_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .FRAMES (FRAMES)
  ) u_addr_gen (
    .frame (frame_q),
    .oy    (oy),
    .ox    (ox),
    .flip  (flip_eff),
    .addr  (rom_addr)
  );

  assign drawing = vld_q[LAT-1] && en && (rom_data != TRANSP);
  assign pix     = drawing ? rom_data : '0;
  assign done    = done_q;

endmodule

// File: tb/tb_sprite_anim.sv
// tb_sprite_anim: directed scoreboard bench for sprite_anim. Instance a uses
// 4x2 sprites, 3 frames, no scaling, ROM latency 1; instance b the same sprite
// scaled 2x3 with ROM latency 2. Expected pixel/done events are queued by the
// stimulus and consumed by a monitor on the falling clock edge.
module tb_sprite_anim;

  localparam int W = 4;
  localparam int H = 2;
  localparam int F = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               en = 1'b1;
  logic               line = 1'b0;
  logic signed [15:0] sx = -16'sd1;
  logic signed [15:0] sy = -16'sd1;
  logic signed [15:0] sprx_a = 16'sd10, spry_a = -16'sd100;
  logic signed [15:0] sprx_b = 16'sd6,  spry_b = -16'sd100;
  logic [1:0]         frame = 2'd0;
  logic               flip = 1'b0;
  logic [4:0]         addr_a, addr_b;
  logic [11:0]        data_a, data_b, data_b1, pix_a, pix_b;
  logic               drw_a, drw_b, done_a, done_b;
  logic [11:0]        rom [0:W*H*F-1];
  logic               mon_on = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         d;
    bit         is_done;
    int         y;
    int         x;
    logic [11:0] c;
  } exp_t;

  exp_t q[$];

  sprite_anim #(
    .WIDTH(W), .HEIGHT(H), .FRAMES(F), .SCALE_X(1), .SCALE_Y(1),
    .COLR_BITS(12), .CORDW(16), .TRANSP(12'h000), .ROM_LAT(1)
  ) dut_a (
    .clk_pix(clk), .rst(rst), .en(en), .line(line), .sx(sx), .sy(sy),
    .sprx(sprx_a), .spry(spry_a), .frame(frame), .flip(flip),
    .rom_addr(addr_a), .rom_data(data_a), .pix(pix_a), .drawing(drw_a), .done(done_a)
  );

  sprite_anim #(
    .WIDTH(W), .HEIGHT(H), .FRAMES(F), .SCALE_X(2), .SCALE_Y(3),
    .COLR_BITS(12), .CORDW(16), .TRANSP(12'h000), .ROM_LAT(2)
  ) dut_b (
    .clk_pix(clk), .rst(rst), .en(en), .line(line), .sx(sx), .sy(sy),
    .sprx(sprx_b), .spry(spry_b), .frame(frame), .flip(flip),
    .rom_addr(addr_b), .rom_data(data_b), .pix(pix_b), .drawing(drw_b), .done(done_b)
  );

  // ROM models: one-cycle and two-cycle synchronous reads.
  always @(posedge clk) data_a <= rom[addr_a];
  always @(posedge clk) begin
    data_b1 <= rom[addr_b];
    data_b  <= data_b1;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_ev(input int d, input bit is_done, input logic [11:0] p);
    exp_t  e;
    string k;
    k = is_done ? "done" : "pix";
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL event_%s: got dut%0d output at y=%0d x=%0d pix=%h, required none",
               k, d, sy, sx, p);
    end else begin
      e = q.pop_front();
      if (e.d != d || e.is_done != is_done || e.y != int'(sy) || e.x != int'(sx) ||
          (!is_done && e.c !== p)) begin
        n_fail++;
        $display("FAIL event_%s: got dut%0d y=%0d x=%0d pix=%h, required dut%0d %s y=%0d x=%0d pix=%h",
                 k, d, sy, sx, p, e.d, e.is_done ? "done" : "pix", e.y, e.x, e.c);
      end
    end
  endtask

  // Monitor: consume one expected event per pixel or done pulse, and require
  // blank colour whenever a pixel is not being drawn.
  always @(negedge clk) begin
    if (mon_on) begin
      if (drw_a)  check_ev(0, 1'b0, pix_a);
      if (done_a) check_ev(0, 1'b1, 12'h000);
      if (drw_b)  check_ev(1, 1'b0, pix_b);
      if (done_b) check_ev(1, 1'b1, 12'h000);
      if (!drw_a) cmp("blank_pix_a", 32'(pix_a), 32'h0);
      if (!drw_b) cmp("blank_pix_b", 32'(pix_b), 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One screen line: strobe cycle at sx=-1, then sx = 0..39.
  task automatic scan_line(input int y);
    tick();
    line = 1'b1;
    sy   = 16'(y);
    sx   = -16'sd1;
    for (int x = 0; x < 40; x++) begin
      tick();
      line = 1'b0;
      sx   = 16'(x);
    end
  endtask

  task automatic push_row(input int d, input int y, input int x0, input int a0,
                          input int step, input int scale);
    for (int c = 0; c < W * scale; c++) begin
      int a;
      a = a0 + step * (c / scale);
      if (rom[a] != 12'h000) q.push_back('{d, 1'b0, y, x0 + c, rom[a]});
    end
  endtask

  task automatic push_done(input int d, input int y, input int x);
    q.push_back('{d, 1'b1, y, x, 12'h000});
  endtask

  initial begin
    bit fl;
`ifdef SPRITE_ANIM_FLIP_EN
    fl = 1'b1;
`else
    fl = 1'b0;
`endif
    for (int k = 0; k < W * H * F; k++) rom[k] = 12'h100 + 12'(k);

    // Reset state
    repeat (3) tick();
    cmp("rst_addr_a", 32'(addr_a), 32'h0);
    cmp("rst_pix_a", 32'(pix_a), 32'h0);
    cmp("rst_drawing_a", 32'(drw_a), 32'h0);
    cmp("rst_done_a", 32'(done_a), 32'h0);
    cmp("rst_addr_b", 32'(addr_b), 32'h0);
    cmp("rst_drawing_b", 32'(drw_b), 32'h0);
    rst    = 1'b0;
    mon_on = 1'b1;

    // Frame 1 with flip requested
    sprx_a = 16'sd10; spry_a = 16'sd5; frame = 2'd1; flip = 1'b1;
    push_row(0, 5, 10, fl ? 11 : 8, fl ? -1 : 1, 1);
    push_row(0, 6, 10, fl ? 15 : 12, fl ? -1 : 1, 1);
    push_done(0, 6, 14);
    for (int y = 4; y <= 7; y++) scan_line(y);
    flip = 1'b0;

    // Transparent column 2 on row 0, enable low for the whole second line
    spry_a = 16'sd10; rom[10] = 12'h000;
    push_row(0, 10, 10, 8, 1, 1);
    push_done(0, 11, 14);
    scan_line(10);
    en = 1'b0;
    scan_line(11);
    en = 1'b1;
    scan_line(12);
    rom[10] = 12'h10a;

    // Out-of-range frame clamps to the last frame; mid-sprite change ignored
    spry_a = 16'sd15; frame = 2'd3;
    push_row(0, 15, 10, 16, 1, 1);
    push_row(0, 16, 10, 20, 1, 1);
    push_done(0, 16, 14);
    scan_line(15);
    frame = 2'd0;
    scan_line(16);
    scan_line(17);

    // Left-clipped sprite: nothing drawn, finishes by line strobes alone
    sprx_a = -16'sd3; spry_a = 16'sd20;
    push_done(0, 22, 1);
    for (int y = 20; y <= 23; y++) scan_line(y);

    // Next sprite renders normally
    sprx_a = 16'sd10; spry_a = 16'sd25;
    push_row(0, 25, 10, 0, 1, 1);
    push_row(0, 26, 10, 4, 1, 1);
    push_done(0, 26, 14);
    for (int y = 25; y <= 27; y++) scan_line(y);

    // Reset during DRAW
    spry_a = 16'sd30;
    q.push_back('{0, 1'b0, 30, 10, rom[0]});
    q.push_back('{0, 1'b0, 30, 11, rom[1]});
    tick();
    line = 1'b1; sy = 16'sd30; sx = -16'sd1;
    for (int x = 0; x <= 11; x++) begin
      tick();
      line = 1'b0;
      sx   = 16'(x);
      if (x == 11) rst = 1'b1;
    end
    tick();
    rst = 1'b0;
    sx  = 16'sd12;
    cmp("midrst_addr", 32'(addr_a), 32'h0);
    cmp("midrst_pix", 32'(pix_a), 32'h0);
    cmp("midrst_drawing", 32'(drw_a), 32'h0);
    cmp("midrst_done", 32'(done_a), 32'h0);
    for (int x = 13; x < 40; x++) begin
      tick();
      sx = 16'(x);
    end
    // Restart from IDLE after the reset
    push_row(0, 30, 10, 0, 1, 1);
    push_row(0, 31, 10, 4, 1, 1);
    push_done(0, 31, 14);
    scan_line(30);
    scan_line(31);

    // Instance b never saw its start line
    cmp("idle_addr_b", 32'(addr_b), 32'h0);
    cmp("idle_done_b", 32'(done_b), 32'h0);

    // Scaled sprite 2x3 with two-cycle ROM
    spry_a = -16'sd100; spry_b = 16'sd40; frame = 2'd1;
    for (int y = 40; y <= 42; y++) push_row(1, y, 6, 8, 1, 2);
    for (int y = 43; y <= 45; y++) push_row(1, y, 6, 12, 1, 2);
    push_done(1, 45, 13);
    for (int y = 40; y <= 46; y++) scan_line(y);

    repeat (4) tick();
    cmp("queue_empty", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
